// File: rtl/dm_responder.sv
// dm_responder: word-addressed data memory with byte-lane stores and a store-log FIFO
// that records {pc, word address, merged word} for every in-range store.
module dm_responder #(
    parameter int DEPTH_WORDS = 3072,
    parameter int LOG_DEPTH   = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [31:0]                  m_data_addr,
    input  logic [31:0]                  m_data_wdata,
    input  logic [3:0]                   m_data_byteen,
    input  logic [31:0]                  m_inst_addr,
    output logic [31:0]                  m_data_rdata,
    output logic                         log_valid,
    input  logic                         log_ready,
    output logic [31:0]                  log_pc,
    output logic [31:0]                  log_addr,
    output logic [31:0]                  log_data,
    output logic [$clog2(LOG_DEPTH):0]   log_count,
    output logic                         log_overflow,
    output logic                         addr_err
);
    localparam int PW = $clog2(LOG_DEPTH);

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_pc [LOG_DEPTH];
    logic [31:0] r_la [LOG_DEPTH];
    logic [31:0] r_ld [LOG_DEPTH];
    logic [PW-1:0] r_wp, r_rp;
    logic [PW:0] r_count;
    logic r_ovf, r_aerr;
    logic [11:0] w_idx;
    logic w_in, w_store, w_pop, w_full, w_push;
    logic [31:0] w_old, w_new;

    assign w_idx   = m_data_addr[13:2];
    assign w_in    = m_data_addr < 32'(DEPTH_WORDS * 4);
    assign w_store = |m_data_byteen;
    assign w_old   = w_in ? r_mem[w_idx] : 32'h0;
    assign w_full  = r_count == (PW+1)'(LOG_DEPTH);
    assign w_pop   = log_valid && log_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign w_push  = w_store && w_in && (!w_full || w_pop);

    always_comb begin
        w_new = w_old;
        for (int i = 0; i < 4; i++)
            w_new[8*i +: 8] = m_data_byteen[i] ? m_data_wdata[8*i +: 8] : w_old[8*i +: 8];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++)
                r_mem[i] <= 32'h0;
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_aerr  <= 1'b0;
        end else begin
            if (w_store && w_in)
                r_mem[w_idx] <= w_new;
            if (w_push) begin
                r_pc[r_wp] <= m_inst_addr;
                r_la[r_wp] <= {m_data_addr[31:2], 2'b00};
                r_ld[r_wp] <= w_new;
                r_wp       <= r_wp + 1'b1;
            end
            if (w_pop)
                r_rp <= r_rp + 1'b1;
            r_count <= r_count + {{PW{1'b0}}, w_push} - {{PW{1'b0}}, w_pop};
            r_ovf   <= r_ovf || (w_store && w_in && w_full && !w_pop);
            r_aerr  <= r_aerr || (w_store && !w_in);
        end
    end

    assign m_data_rdata = w_old;
    assign log_valid    = r_count != '0;
    assign log_pc       = log_valid ? r_pc[r_rp] : 32'h0;
    assign log_addr     = log_valid ? r_la[r_rp] : 32'h0;
    assign log_data     = log_valid ? r_ld[r_rp] : 32'h0;
    assign log_count    = r_count;
    assign log_overflow = r_ovf;
    assign addr_err     = r_aerr;
endmodule

// File: tb/tb_dm_responder.sv
// tb_dm_responder: directed-step bench for dm_responder with immediate assertions.
module tb_dm_responder;
    logic clk = 1'b0, reset = 1'b1, log_ready = 1'b0;
    logic [31:0] m_data_addr = '0, m_data_wdata = '0, m_inst_addr = '0;
    logic [3:0] m_data_byteen = '0;
    logic [31:0] m_data_rdata, log_pc, log_addr, log_data;
    logic [2:0] log_count;
    logic log_valid, log_overflow, addr_err;
    int errors = 0, checks = 0;

    dm_responder dut (
        .clk(clk), .reset(reset), .m_data_addr(m_data_addr), .m_data_wdata(m_data_wdata),
        .m_data_byteen(m_data_byteen), .m_inst_addr(m_inst_addr), .m_data_rdata(m_data_rdata),
        .log_valid(log_valid), .log_ready(log_ready), .log_pc(log_pc), .log_addr(log_addr),
        .log_data(log_data), .log_count(log_count), .log_overflow(log_overflow), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic st(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d, input logic [31:0] pc);
        m_data_addr = a; m_data_byteen = be; m_data_wdata = d; m_inst_addr = pc;
        tick;
        m_data_byteen = 4'h0;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        m_data_addr = a;
        #1;
        chk(tag, m_data_rdata, exp);
    endtask

    task automatic head(input string tag, input logic [31:0] pc, input logic [31:0] a, input logic [31:0] d);
        chk({tag, "_pc"}, log_pc, pc);
        chk({tag, "_addr"}, log_addr, a);
        chk({tag, "_data"}, log_data, d);
    endtask

    initial begin
        tick;
        reset = 1'b0;
        chk("rst_count", {29'd0, log_count}, 32'd0);
        chk("rst_valid", {31'd0, log_valid}, 32'd0);
        chk("rst_ovf", {31'd0, log_overflow}, 32'd0);
        chk("rst_aerr", {31'd0, addr_err}, 32'd0);
        head("rst_head", 32'h0, 32'h0, 32'h0);
        rd("rst_rd10", 32'h10, 32'h0);

        // full-word store; rdata is pre-edge before the clock
        m_data_addr = 32'h10; m_data_byteen = 4'hF; m_data_wdata = 32'h12345678; m_inst_addr = 32'h3000;
        #1;
        chk("pre_edge_rd", m_data_rdata, 32'h0);
        tick;
        m_data_byteen = 4'h0;
        rd("full_rd", 32'h10, 32'h12345678);
        chk("full_valid", {31'd0, log_valid}, 32'd1);
        chk("full_count", {29'd0, log_count}, 32'd1);
        head("full_head", 32'h3000, 32'h10, 32'h12345678);

        // byte merge on lane 2, unaligned address
        st(32'h12, 4'b0100, 32'h00AB0000, 32'h3004);
        rd("merge_rd", 32'h10, 32'h12AB5678);
        chk("merge_count", {29'd0, log_count}, 32'd2);
        head("stable_head", 32'h3000, 32'h10, 32'h12345678);
        log_ready = 1'b1;
        tick;
        head("merge_head", 32'h3004, 32'h10, 32'h12AB5678);
        tick;
        log_ready = 1'b0;
        chk("drain_count", {29'd0, log_count}, 32'd0);
        head("empty_head", 32'h0, 32'h0, 32'h0);

        // back-to-back stores to one word log the cumulative value
        st(32'h10, 4'b0001, 32'h000000EF, 32'h3008);
        st(32'h13, 4'b1000, 32'hCD000000, 32'h300C);
        chk("b2b_count", {29'd0, log_count}, 32'd2);
        head("b2b_h1", 32'h3008, 32'h10, 32'h12AB56EF);
        log_ready = 1'b1;
        tick;
        head("b2b_h2", 32'h300C, 32'h10, 32'hCDAB56EF);
        tick;
        log_ready = 1'b0;

        // overflow: five stores into a 4-deep FIFO, memory still written
        for (int k = 0; k < 5; k++)
            st(32'h20 + 32'(4*k), 4'hF, 32'hA0 + 32'(k), 32'h100 + 32'(k));
        chk("ovf_count", {29'd0, log_count}, 32'd4);
        chk("ovf_flag", {31'd0, log_overflow}, 32'd1);
        rd("ovf_mem", 32'h30, 32'hA4);
        head("ovf_head", 32'h100, 32'h20, 32'hA0);
        log_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            tick;
            head("ovf_drain", 32'h100 + 32'(k), 32'h20 + 32'(4*k), 32'hA0 + 32'(k));
        end
        tick;
        log_ready = 1'b0;
        chk("ovf_empty", {29'd0, log_count}, 32'd0);
        chk("ovf_sticky", {31'd0, log_overflow}, 32'd1);

        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("ovf_rst", {31'd0, log_overflow}, 32'd0);

        // full FIFO with simultaneous push and pop
        for (int k = 0; k < 4; k++)
            st(32'h40 + 32'(4*k), 4'hF, 32'hB0 + 32'(k), 32'h200 + 32'(k));
        chk("pp_full", {29'd0, log_count}, 32'd4);
        log_ready = 1'b1;
        st(32'h50, 4'hF, 32'hB4, 32'h204);
        chk("pp_count", {29'd0, log_count}, 32'd4);
        chk("pp_ovf", {31'd0, log_overflow}, 32'd0);
        head("pp_h1", 32'h201, 32'h44, 32'hB1);
        for (int k = 2; k < 5; k++) begin
            tick;
            head("pp_drain", 32'h200 + 32'(k), 32'h40 + 32'(4*k), 32'hB0 + 32'(k));
        end
        tick;
        log_ready = 1'b0;
        chk("pp_empty", {29'd0, log_count}, 32'd0);

        // range boundary: last word in range, first word out of range
        st(32'h2FFC, 4'hF, 32'h11223344, 32'h300);
        rd("edge_rd", 32'h2FFC, 32'h11223344);
        chk("edge_count", {29'd0, log_count}, 32'd1);
        chk("edge_aerr", {31'd0, addr_err}, 32'd0);
        st(32'h3000, 4'hF, 32'hDEADBEEF, 32'h304);
        chk("oor_aerr", {31'd0, addr_err}, 32'd1);
        chk("oor_count", {29'd0, log_count}, 32'd1);
        rd("oor_rd", 32'h3000, 32'h0);
        rd("oor_word0", 32'h0, 32'h0);

        // reset with a concurrent store while FIFO holds three entries
        st(32'h60, 4'hF, 32'h55, 32'h308);
        st(32'h64, 4'hF, 32'h66, 32'h30C);
        chk("pre_rst_count", {29'd0, log_count}, 32'd3);
        m_data_addr = 32'h68; m_data_byteen = 4'hF; m_data_wdata = 32'h77; reset = 1'b1;
        tick;
        reset = 1'b0; m_data_byteen = 4'h0;
        chk("mid_rst_count", {29'd0, log_count}, 32'd0);
        chk("mid_rst_valid", {31'd0, log_valid}, 32'd0);
        chk("mid_rst_aerr", {31'd0, addr_err}, 32'd0);
        chk("mid_rst_ovf", {31'd0, log_overflow}, 32'd0);
        head("mid_rst_head", 32'h0, 32'h0, 32'h0);
        rd("mid_rst_10", 32'h10, 32'h0);
        rd("mid_rst_2ffc", 32'h2FFC, 32'h0);
        rd("mid_rst_60", 32'h60, 32'h0);
        rd("mid_rst_68", 32'h68, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
